split_ctrl: RTL and testbench
=============================

// Module: split_ctrl
// PURPOSE
//  Sequencer for the split line buffer: pulls one BURST_LENGTH-word burst at a time from the DMA read stream,
//  writes it into split, then drains it with read strobes paced by PE back-pressure.
//  Repeats for cfg_bursts bursts per job. Sits between the DMA read channel, split and the PE array.
//  split dout/valid go to the PE array directly; this block only drives split's control pins.
// PARAMETERS
//  DATA_WIDTH       32  word width of dma_data / split_din
//  BURST_LENGTH     32  words written into split per burst (split depth)
//  KERNEL_LENGTH    3   kernel rows presented in parallel by split
//  READS_PER_BURST  BURST_LENGTH-KERNEL_LENGTH+1  ren strobes issued per burst
//  CNT_WIDTH        16  width of cfg_bursts and the burst counter
// PORTS
//  clk          in   1           clock, rising edge
//  rst          in   1           asynchronous, active-high reset
//  start        in   1           job start pulse; sampled only in IDLE
//  cfg_bursts   in   CNT_WIDTH   bursts in the job; latched on accepted start
//  busy         out  1           high from the cycle after accepted start until done
//  done         out  1           one-cycle pulse at job end
//  dma_valid    in   1           DMA word valid
//  dma_data     in   DATA_WIDTH  DMA word
//  dma_ready    out  1           controller accepts dma_data this cycle
//  split_wen    out  1           split write enable
//  split_din    out  DATA_WIDTH  split write data
//  split_ren    out  1           split read enable
//  split_full   in   1           split full_flag
//  split_empty  in   1           split empty_flag
//  pe_ready     in   1           PE array can take a split output this cycle
// BEHAVIOUR
//  Reset: state=IDLE, counters=0, busy=0, done=0; dma_ready, split_wen, split_ren=0; split_din=0.
//  FSM states IDLE, FILL, DRAIN, DONE (registered state; strobes combinational from state and inputs).
//  IDLE: start && cfg_bursts!=0 -> latch cfg_bursts, clear word_cnt/rd_cnt/burst_cnt, go to FILL.
//    start && cfg_bursts==0 -> go to DONE directly (no DMA or split traffic).
//  FILL: dma_ready = !split_full. Transfer = dma_valid && dma_ready.
//    On a transfer: split_wen=1 and split_din=dma_data in the same cycle; word_cnt++.
//    Transfer with word_cnt==BURST_LENGTH-1 -> word_cnt=0, go to DRAIN.
//    split_full before the last word: stall (dma_ready=0); no word is dropped.
//  DRAIN: dma_ready=0. split_ren = pe_ready && !split_empty; each strobe rd_cnt++.
//    Strobe with rd_cnt==READS_PER_BURST-1 -> rd_cnt=0, burst_cnt++.
//      Then go to DONE if burst_cnt==latched-1, otherwise go to FILL.
//  DONE: done=1 for exactly one cycle, go to IDLE; busy=0 from the following cycle.
//  busy = (state != IDLE), registered.
//  Outside their states, split_wen and split_ren are 0. They are never both 1 in the same cycle.
//  Counters wrap-free: word_cnt in [0, BURST_LENGTH-1], rd_cnt in [0, READS_PER_BURST-1].
//  start while busy: ignored; latched cfg_bursts does not change mid-job.
//  rst mid-job: immediate return to reset values; a partially written split burst is abandoned.
//    The split buffer shares rst, so it is cleared too.
// CONFIGURATION
//  SPLIT_CTRL_PERF_EN defined: adds output stall_cnt [31:0].
//    stall_cnt increments each busy cycle where (FILL && dma_valid && split_full) || (DRAIN && !pe_ready).
//    It clears on accepted start and on rst, and saturates at 32'hFFFF_FFFF.
//  SPLIT_CTRL_PERF_EN undefined: no port, no counter logic; all other behaviour identical.
// TESTING
//  1 Reset: rst=1 mid-FILL after 10 words -> next edge all outputs 0; state IDLE.
//    A new start then needs the full 32 words again.
//  2 One burst: cfg_bursts=1, dma_valid held 1, pe_ready held 1.
//    -> 32 split_wen cycles with din=dma_data, then 30 split_ren, then one done pulse; busy low after.
//  3 Three bursts: cfg_bursts=3 -> 96 writes and 90 reads in FILL/DRAIN alternation.
//    Exactly one done pulse; start pulses sent during the job are ignored.
//  4 Back-pressure: dma_valid toggles every cycle; pe_ready low for 5 cycles mid-DRAIN.
//    -> no split_ren while pe_ready=0; totals still 32 writes and 30 reads.
//    With SPLIT_CTRL_PERF_EN: stall_cnt=5.
//  5 Full stall: split_full forced 1 at word 20 for 4 cycles.
//    -> dma_ready=0 and split_wen=0 for those 4 cycles; resumes at word 20, no loss or duplicate.
//  6 Zero job: start with cfg_bursts=0 -> busy high 1 cycle, done next cycle, no wen/ren/dma_ready.

Source files
------------

// File: rtl/split_ctrl.sv
// -----------------------------------------------------------------------------
// split_ctrl
//   Sequencer for the split line buffer. Pulls one BURST_LENGTH-word burst from
//   the DMA read stream into split, then drains it with READS_PER_BURST read
//   strobes paced by PE back-pressure. Repeats for the latched number of bursts
//   per job. split dout/valid go straight to the PE array; this block only
//   drives split's control pins.
//
//   Optional feature: define SPLIT_CTRL_PERF_EN to add o_stall_cnt, a
//   saturating count of busy cycles lost to split-full or PE back-pressure.
//
// Ports
//   i_clk           clock, rising edge
//   i_rst           asynchronous active-high reset
//   i_start         job start pulse, sampled only while idle
//   i_cfg_bursts    bursts in the job, latched on accepted start
//   o_busy          high from the cycle after accepted start until done
//   o_done          one-cycle pulse at job end
//   i_dma_valid     DMA word valid
//   i_dma_data      DMA word
//   o_dma_ready     controller accepts i_dma_data this cycle
//   o_split_wen     split write enable
//   o_split_din     split write data (zero when not writing)
//   o_split_ren     split read enable
//   i_split_full    split full flag
//   i_split_empty   split empty flag
//   i_pe_ready      PE array can take a split output this cycle
//   o_stall_cnt     (SPLIT_CTRL_PERF_EN only) stall cycle counter
// -----------------------------------------------------------------------------
module split_ctrl #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned BURST_LENGTH    = 32,
    parameter int unsigned KERNEL_LENGTH   = 3,
    parameter int unsigned READS_PER_BURST = BURST_LENGTH - KERNEL_LENGTH + 1,
    parameter int unsigned CNT_WIDTH       = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [CNT_WIDTH-1:0]  i_cfg_bursts,
    output logic                  o_busy,
    output logic                  o_done,
    input  logic                  i_dma_valid,
    input  logic [DATA_WIDTH-1:0] i_dma_data,
    output logic                  o_dma_ready,
    output logic                  o_split_wen,
    output logic [DATA_WIDTH-1:0] o_split_din,
    output logic                  o_split_ren,
    input  logic                  i_split_full,
    input  logic                  i_split_empty,
    input  logic                  i_pe_ready
`ifdef SPLIT_CTRL_PERF_EN
    ,
    output logic [31:0]           o_stall_cnt
`endif
);

    localparam int unsigned WC_W = (BURST_LENGTH > 1) ? $clog2(BURST_LENGTH) : 1;
    localparam int unsigned RC_W = (READS_PER_BURST > 1) ? $clog2(READS_PER_BURST) : 1;
    localparam logic [WC_W-1:0] LAST_WORD = WC_W'(BURST_LENGTH - 1);
    localparam logic [RC_W-1:0] LAST_READ = RC_W'(READS_PER_BURST - 1);

    typedef enum logic [1:0] {StIdle, StFill, StDrain, StDone} state_t;

    state_t               r_state;
    logic [WC_W-1:0]      r_word_cnt;
    logic [RC_W-1:0]      r_rd_cnt;
    logic [CNT_WIDTH-1:0] r_burst_cnt;
    logic [CNT_WIDTH-1:0] r_bursts;
    logic                 r_busy;
    logic                 r_done;

    logic w_fill;
    logic w_drain;
    logic w_accept;
    logic w_wen;
    logic w_ren;
    logic w_last_burst;

    // Strobes are combinational so a word moves in the same cycle it is offered.
    assign w_fill       = (r_state == StFill);
    assign w_drain      = (r_state == StDrain);
    assign w_accept     = (r_state == StIdle) && i_start;
    assign o_dma_ready  = w_fill && !i_split_full;
    assign w_wen        = o_dma_ready && i_dma_valid;
    assign w_ren        = w_drain && i_pe_ready && !i_split_empty;
    assign w_last_burst = (r_burst_cnt == (r_bursts - CNT_WIDTH'(1)));

    assign o_split_wen = w_wen;
    assign o_split_din = w_wen ? i_dma_data : '0;
    assign o_split_ren = w_ren;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_word_cnt  <= '0;
            r_rd_cnt    <= '0;
            r_burst_cnt <= '0;
            r_bursts    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_busy <= 1'b1;
                        if (i_cfg_bursts != '0) begin
                            r_bursts    <= i_cfg_bursts;
                            r_word_cnt  <= '0;
                            r_rd_cnt    <= '0;
                            r_burst_cnt <= '0;
                            r_state     <= StFill;
                        end else begin
                            // Empty job: report completion without touching DMA or split.
                            r_done  <= 1'b1;
                            r_state <= StDone;
                        end
                    end
                end
                StFill: begin
                    if (w_wen) begin
                        if (r_word_cnt == LAST_WORD) begin
                            r_word_cnt <= '0;
                            r_state    <= StDrain;
                        end else begin
                            r_word_cnt <= r_word_cnt + WC_W'(1);
                        end
                    end
                end
                StDrain: begin
                    if (w_ren) begin
                        if (r_rd_cnt == LAST_READ) begin
                            r_rd_cnt    <= '0;
                            r_burst_cnt <= r_burst_cnt + CNT_WIDTH'(1);
                            if (w_last_burst) begin
                                r_done  <= 1'b1;
                                r_state <= StDone;
                            end else begin
                                r_state <= StFill;
                            end
                        end else begin
                            r_rd_cnt <= r_rd_cnt + RC_W'(1);
                        end
                    end
                end
                StDone: begin
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

`ifdef SPLIT_CTRL_PERF_EN
    logic [31:0] r_stall_cnt;
    logic        w_stall;

    assign w_stall     = r_busy && ((w_fill && i_dma_valid && i_split_full) ||
                                    (w_drain && !i_pe_ready));
    assign o_stall_cnt = r_stall_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stall_cnt <= '0;
        end else if (w_accept) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end
`else
    logic w_unused;
    assign w_unused = w_accept;
`endif

endmodule

// File: tb/tb_split_ctrl.sv
// -----------------------------------------------------------------------------
// tb_split_ctrl
//   Self-checking bench for split_ctrl. A job-level reference model tracks
//   total words written and read per job; the expected phase follows from
//   those totals (fill until BURST_LENGTH*(completed bursts + 1) words are
//   written, otherwise drain) and the job ends when READS_PER_BURST*bursts
//   reads have been made. Define SPLIT_CTRL_PERF_EN to also check o_stall_cnt.
// -----------------------------------------------------------------------------
module tb_split_ctrl;

    localparam int DW  = 32;
    localparam int BL  = 32;
    localparam int RPB = 30;
    localparam int CW  = 16;
    localparam int GUARD = 3000;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] cfg_bursts;
    logic          busy;
    logic          done;
    logic          dma_valid;
    logic [DW-1:0] dma_data;
    logic          dma_ready;
    logic          split_wen;
    logic [DW-1:0] split_din;
    logic          split_ren;
    logic          split_full;
    logic          split_empty;
    logic          pe_ready;
`ifdef SPLIT_CTRL_PERF_EN
    logic [31:0]   stall_cnt;
`endif

    always #5 clk = ~clk;

    split_ctrl dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_cfg_bursts (cfg_bursts),
        .o_busy       (busy),
        .o_done       (done),
        .i_dma_valid  (dma_valid),
        .i_dma_data   (dma_data),
        .o_dma_ready  (dma_ready),
        .o_split_wen  (split_wen),
        .o_split_din  (split_din),
        .o_split_ren  (split_ren),
        .i_split_full (split_full),
        .i_split_empty(split_empty),
        .i_pe_ready   (pe_ready)
`ifdef SPLIT_CTRL_PERF_EN
        ,
        .o_stall_cnt  (stall_cnt)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: job-level totals.
    bit     m_active = 0;
    bit     m_fin    = 0;
    int     m_n      = 0;
    int     m_w      = 0;
    int     m_r      = 0;
    longint m_stall  = 0;

    // Tallies of observed DUT strobes within the current job.
    int j_wen  = 0;
    int j_ren  = 0;
    int j_done = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_fill();
        return m_active && (m_w < BL * (m_r / RPB + 1));
    endfunction

    function automatic bit model_drain();
        return m_active && !model_fill();
    endfunction

    task automatic model_reset();
        m_active = 0;
        m_fin    = 0;
        m_n      = 0;
        m_w      = 0;
        m_r      = 0;
        m_stall  = 0;
    endtask

    // One clock cycle: drive inputs on the falling edge, check, advance model.
    task automatic step(input bit st, input int unsigned cfg, input bit v, input bit full,
                        input bit empty, input bit pr);
        bit          fill;
        bit          drain;
        bit          e_ready;
        bit          e_wen;
        bit          e_ren;
        logic [DW-1:0] e_din;
        @(negedge clk);
        start       = st;
        cfg_bursts  = CW'(cfg);
        dma_valid   = v;
        dma_data    = $urandom;
        split_full  = full;
        split_empty = empty;
        pe_ready    = pr;
        #1;
        fill    = model_fill();
        drain   = model_drain();
        e_ready = fill && !full;
        e_wen   = e_ready && v;
        e_ren   = drain && pr && !empty;
        e_din   = e_wen ? dma_data : '0;
        check("dma_ready", dma_ready, e_ready);
        check("split_wen", split_wen, e_wen);
        check("split_din", split_din, e_din);
        check("split_ren", split_ren, e_ren);
        check("busy", busy, m_active || m_fin);
        check("done", done, m_fin);
        check("wen_ren_excl", split_wen && split_ren, 0);
`ifdef SPLIT_CTRL_PERF_EN
        check("stall_cnt", stall_cnt, m_stall);
`endif
        j_wen  += int'(split_wen);
        j_ren  += int'(split_ren);
        j_done += int'(done);
        if (m_active && ((fill && v && full) || (drain && !pr)) && m_stall < 64'hFFFF_FFFF)
            m_stall++;
        if (m_fin) begin
            m_fin = 0;
        end else if (!m_active) begin
            if (st) begin
                m_stall = 0;
                j_wen   = 0;
                j_ren   = 0;
                j_done  = 0;
                if (cfg == 0) begin
                    m_fin = 1;
                end else begin
                    m_active = 1;
                    m_n      = int'(cfg);
                    m_w      = 0;
                    m_r      = 0;
                end
            end
        end else begin
            m_w += int'(e_wen);
            m_r += int'(e_ren);
            if (m_r == RPB * m_n) begin
                m_active = 0;
                m_fin    = 1;
            end
        end
    endtask

    // mode 0: steady streams; 1: valid toggles, pe_ready low 5 cycles mid-drain;
    // 2: split_full for 4 cycles at word 20; 3: fully random; 4: steady with stray starts.
    task automatic run_job(input int unsigned cfg, input int mode);
        int guard     = 0;
        int pr_left   = 0;
        bit pr_done   = 0;
        int full_left = 0;
        bit full_done = 0;
        bit v, f, e, p, st;
        int unsigned c;
        step(1, cfg, 1, 0, 0, 1);
        while ((m_active || m_fin) && guard < GUARD) begin
            v = 1; f = 0; e = 0; p = 1; st = 0; c = cfg;
            case (mode)
                1: begin
                    v = guard[0];
                    if (!pr_done && model_drain() && (m_r % RPB) == 10) begin
                        pr_left = 5;
                        pr_done = 1;
                    end
                    if (pr_left > 0) begin
                        p = 0;
                        pr_left--;
                    end
                end
                2: begin
                    if (!full_done && model_fill() && (m_w % BL) == 20) begin
                        full_left = 4;
                        full_done = 1;
                    end
                    if (full_left > 0) begin
                        f = 1;
                        full_left--;
                    end
                end
                3: begin
                    v  = ($urandom_range(0, 3) != 0);
                    f  = ($urandom_range(0, 7) == 0);
                    e  = ($urandom_range(0, 7) == 0);
                    p  = ($urandom_range(0, 3) != 0);
                    st = ($urandom_range(0, 6) == 0);
                    c  = $urandom_range(0, 3);
                end
                4: begin
                    st = ($urandom_range(0, 6) == 0);
                    c  = $urandom_range(0, 5);
                end
                default: ;
            endcase
            step(st, c, v, f, e, p);
            guard++;
        end
        check("job_in_bound", guard < GUARD, 1);
        check("job_writes", j_wen, BL * cfg);
        check("job_reads", j_ren, RPB * cfg);
        check("job_done_pulses", j_done, 1);
    endtask

    initial begin
        rst = 1; start = 0; cfg_bursts = '0; dma_valid = 0; dma_data = '0;
        split_full = 0; split_empty = 0; pe_ready = 0;
        model_reset();
        @(negedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ready", dma_ready, 0);
        check("rst_wen", split_wen, 0);
        check("rst_ren", split_ren, 0);
        check("rst_din", split_din, 0);
        rst = 0;

        // Reset mid-fill after 10 words, then a full job needs all 32 again.
        step(1, 1, 1, 0, 0, 1);
        for (int i = 0; i < 10; i++) step(0, 1, 1, 0, 0, 1);
        check("pre_rst_words", j_wen, 10);
        @(negedge clk);
        rst = 1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_ready", dma_ready, 0);
        check("midrst_wen", split_wen, 0);
        check("midrst_din", split_din, 0);
        model_reset();
        @(negedge clk);
        rst = 0;
        run_job(1, 0);

        run_job(1, 0);
        run_job(3, 4);
        run_job(1, 1);
`ifdef SPLIT_CTRL_PERF_EN
        check("stall_backpressure", stall_cnt, 5);
`endif
        run_job(1, 2);
        run_job(0, 0);
        for (int k = 0; k < 3; k++) run_job($urandom_range(1, 2), 3);
        step(0, 0, 1, 0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
